// File: rtl/and_gate.sv
// Bitwise AND of a and b: a combinational result, plus a registered, valid-qualified copy.
// Define AND_GATE_STATS_EN to add ones_cnt, a saturating count of valid all-ones samples.
module and_gate #(
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 in_valid,
  output logic [WIDTH-1:0]     y,
  output logic [WIDTH-1:0]     y_q,
  output logic                 out_valid,
  output logic                 all_ones
`ifdef AND_GATE_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] ones_cnt
`endif
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_and
      assign y[gi] = a[gi] & b[gi];
    end
  endgenerate

  assign all_ones = &y;

  // y_q holds its last capture across idle cycles; only out_valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y_q <= y;
      end
    end
  end

`ifdef AND_GATE_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      ones_cnt <= '0;
    end else if (in_valid && all_ones && (ones_cnt != CNT_MAX)) begin
      ones_cnt <= ones_cnt + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_and_gate.sv
// Testbench for and_gate: a scoreboard of expected registered results, fed by the driver and
// drained by an independent monitor, plus direct checks of the combinational outputs.
module tb_and_gate;

  localparam int W  = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  a, b;
  logic          in_valid;
  logic [W-1:0]  y, y_q;
  logic          out_valid, all_ones;
`ifdef AND_GATE_STATS_EN
  logic [CW-1:0] ones_cnt;
`endif

  logic a1, b1, in_valid1, y1, y1_q, out_valid1, all_ones1;

  always #5 clk = ~clk;

  and_gate #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
    .y(y), .y_q(y_q), .out_valid(out_valid), .all_ones(all_ones)
`ifdef AND_GATE_STATS_EN
    , .ones_cnt(ones_cnt)
`endif
  );

  and_gate #(.WIDTH(1), .CNT_WIDTH(CW)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(in_valid1),
    .y(y1), .y_q(y1_q), .out_valid(out_valid1), .all_ones(all_ones1)
`ifdef AND_GATE_STATS_EN
    , .ones_cnt()
`endif
  );

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    int           cnt;
  } exp_t;

  exp_t          sb[$];
  int            compared   = 0;
  int            mismatched = 0;
  int            txn        = 0;
  logic [W-1:0]  held       = '0;
  int            cnt_model  = 0;
  bit            done       = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: y_q remembers the latest accepted product, the counter counts
  // accepted all-ones products and stops at its maximum.
  task automatic cycle(input logic r, input logic iv, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    logic [W-1:0] prod;
    @(negedge clk);
    rst = r; in_valid = iv; a = av; b = bv;
    prod = av & bv;
    if (r) begin
      held = '0; cnt_model = 0; e.v = 1'b0;
    end else if (iv) begin
      held = prod; e.v = 1'b1;
      if (int'(prod) == (2**W - 1) && cnt_model < (2**CW - 1)) cnt_model++;
    end else begin
      e.v = 1'b0;
    end
    e.d = held; e.cnt = cnt_model;
    sb.push_back(e);
    #1;
    chk("y", 32'(y), 32'(prod));
    chk("all_ones", 32'(all_ones), 32'(int'(prod) == (2**W - 1)));
  endtask

  // Monitor: one scoreboard entry is due after every clock edge that followed a drive.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        txn++;
        $display("txn %0d: out_valid=%b y_q=%h (exp %b/%h)", txn, out_valid, y_q, e.v, e.d);
        chk("out_valid", 32'(out_valid), 32'(e.v));
        chk("y_q", 32'(y_q), 32'(e.d));
`ifdef AND_GATE_STATS_EN
        chk("ones_cnt", 32'(ones_cnt), 32'(e.cnt));
`endif
      end
    end
  end

  initial begin
    int wait_cycles;
    logic [3:0] pat;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; in_valid1 = 1'b0;
    a1 = 1'b0; b1 = 1'b0;

    // WIDTH=1 truth table, twice through with a repeated tail, no clock dependence.
    for (int i = 0; i < 12; i++) begin
      pat = (i < 4) ? 4'(i) : 4'(i - 4);
      if (i >= 8) pat = (i < 10) ? 4'd0 : 4'd3;
      if (i >= 4 && i < 8) pat = 4'(i - 4);
      a1 = pat[1]; b1 = pat[0];
      #1;
      chk("y1", 32'(y1), 32'(pat[1] & pat[0]));
      chk("all_ones1", 32'(all_ones1), 32'(pat[1] & pat[0]));
      #9;
    end

    cycle(1'b1, 1'b0, '0, '0);
    cycle(1'b0, 1'b1, 8'hF0, 8'h3C);
    cycle(1'b0, 1'b0, 8'h00, 8'h00);
    cycle(1'b0, 1'b0, 8'h55, 8'hAA);
    cycle(1'b1, 1'b1, 8'hFF, 8'hFF);

    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'hFF, 8'hFF);
    cycle(1'b1, 1'b0, 8'hFF, 8'hFF);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'hFF, 8'hFF);
    cycle(1'b0, 1'b1, 8'hFF, 8'hFF);
    cycle(1'b0, 1'b1, 8'hFE, 8'hFF);

    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? 8'hFF : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 8'hFF : W'($urandom);
      cycle($urandom_range(0, 19) == 0, 1'($urandom), ra, rb);
    end

    @(negedge clk);
    in_valid = 1'b0; rst = 1'b0;
    wait_cycles = 0;
    while (sb.size() != 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
